// File: rtl/buffer_reader_if.sv
// Buffer read port plus downstream valid/ready stream of the buffer_reader block.
// The master modport is the reader engine; the slave side is the buffer and consumer.
interface buffer_reader_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             buf_empty;
  logic             buf_rd;
  logic [WIDTH-1:0] buf_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] words_out;

  modport master (
    input  buf_empty, buf_data, out_ready,
    output buf_rd, out_valid, out_data, words_out
  );

  modport slave (
    output buf_empty, buf_data, out_ready,
    input  buf_rd, out_valid, out_data, words_out
  );
endinterface

// File: rtl/buffer_reader.sv
// Read-side engine: pops a one-cycle-latency buffer into a 2-entry output queue
// with credit-based issue, so the downstream stream sustains one word per cycle.
module buffer_reader #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  buffer_reader_if.master   bus
);

  localparam int unsigned OCC_W = 2;

  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [OCC_W-1:0] occ;
  logic             inflight;
  logic [CNT_W-1:0] count_q;

  logic             pop;
  logic             rd_c;
  logic [OCC_W-1:0] credit;
  logic [OCC_W-1:0] slot;

  // Credit counts free queue slots not already claimed by an in-flight pop.
  always_comb begin
    pop    = (occ != OCC_W'(0)) & bus.out_ready;
    credit = OCC_W'(2) - occ - OCC_W'(inflight) + OCC_W'(pop);
    rd_c   = !reset & !bus.buf_empty & (credit != OCC_W'(0));
    slot   = occ - OCC_W'(pop);
  end

  assign bus.buf_rd    = rd_c;
  assign bus.out_valid = (occ != OCC_W'(0));
  assign bus.out_data  = q0;
  assign bus.words_out = count_q;

  // Shift on pop, then land the arriving word; a slot-0 write overrides the shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q0       <= '0;
      q1       <= '0;
      occ      <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      inflight <= rd_c;
      occ      <= occ + OCC_W'(inflight) - OCC_W'(pop);
      if (pop) begin
        q0      <= q1;
        count_q <= count_q + CNT_W'(1);
      end
      if (inflight) begin
        if (slot == OCC_W'(0)) q0 <= bus.buf_data;
        else                   q1 <= bus.buf_data;
      end
    end
  end

endmodule

// File: tb/tb_buffer_reader.sv
// Directed and random bench for buffer_reader with a one-cycle-latency buffer model
// and an in-order scoreboard on the output stream.
module tb_buffer_reader;

  logic clk;
  logic reset;

  buffer_reader_if #(.WIDTH(32), .CNT_W(16)) bus ();
  buffer_reader_if #(.WIDTH(32), .CNT_W(4))  bus4 ();

  buffer_reader #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  buffer_reader #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.master)
  );

  // The narrow-counter instance shadows the main one on identical inputs.
  assign bus4.buf_empty = bus.buf_empty;
  assign bus4.buf_data  = bus.buf_data;
  assign bus4.out_ready = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          push_n;
    logic [31:0] push_base;
    logic        ready;
    logic        exp_rd;
    logic        exp_valid;
    logic [31:0] exp_data;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] src[$];
  logic [31:0] exp_q[$];
  logic        hold_empty;
  logic        rd_seen;
  int          issued;
  int          delivered;
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic refresh_empty();
    bus.buf_empty = hold_empty || (src.size() == 0);
  endtask

  // One clock: monitor at the falling edge, then buffer model just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (reset) begin
      rd_seen = 1'b0;
    end else begin
      check("rd_while_empty", 32'(bus.buf_rd & bus.buf_empty), 32'd0);
      checks++;
      if (issued - delivered > 2) begin
        errors++;
        $display("FAIL outstanding: got %0d words read but undelivered, required at most 2", issued - delivered);
      end
      rd_seen = bus.buf_rd;
      if (bus.buf_rd) issued++;
      if (bus.out_valid && bus.out_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_data: got %h, required no word (scoreboard empty)", bus.out_data);
        end else begin
          check("stream_data", bus.out_data, exp_q.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    if (rd_seen) begin
      if (src.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL buffer_underflow: got pop of empty buffer, required none");
      end else begin
        bus.buf_data = src.pop_front();
        exp_q.push_back(bus.buf_data);
      end
    end
    refresh_empty();
  endtask

  task automatic run_vecs(input string name);
    for (int i = 0; i < vecs.size(); i++) begin
      tick();
      for (int k = 0; k < vecs[i].push_n; k++) src.push_back(vecs[i].push_base + 32'(k));
      bus.out_ready = vecs[i].ready;
      refresh_empty();
      #3;
      check({name, "_rd"},    32'(bus.buf_rd),    32'(vecs[i].exp_rd));
      check({name, "_valid"}, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check({name, "_data"}, bus.out_data, vecs[i].exp_data);
    end
    vecs.delete();
  endtask

  // Asynchronous mid-cycle reset; the buffer itself keeps its contents.
  task automatic do_reset(input logic rd_after);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data",  bus.out_data,       32'd0);
    check("rst_count", 32'(bus.words_out), 32'd0);
    check("rst_rd",    32'(bus.buf_rd),    32'd0);
    exp_q.delete();
    issued    = 0;
    delivered = 0;
    tick();
    reset = 1'b0;
    refresh_empty();
    #3;
    check("rst_first_rd", 32'(bus.buf_rd), 32'(rd_after));
  endtask

  initial begin
    vec_t v;
    int   pushed;
    int   cyc;
    int   n;

    checks        = 0;
    errors        = 0;
    issued        = 0;
    delivered     = 0;
    rd_seen       = 1'b0;
    hold_empty    = 1'b0;
    reset         = 1'b1;
    bus.out_ready = 1'b0;
    bus.buf_data  = '0;
    refresh_empty();

    #2;
    check("init_valid", 32'(bus.out_valid), 32'd0);
    check("init_data",  bus.out_data,       32'd0);
    check("init_count", 32'(bus.words_out), 32'd0);
    check("init_rd",    32'(bus.buf_rd),    32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Single word appears at cycle 10.
    for (int c = 0; c < 16; c++) begin
      v = '{(c == 10) ? 1 : 0, 32'hDEADBEEF, 1'b1, c == 10, c == 12, 32'hDEADBEEF};
      vecs.push_back(v);
    end
    run_vecs("single");
    check("single_count", 32'(bus.words_out), 32'd1);

    // Burst of 1..8 at full rate.
    for (int c = 0; c < 12; c++) begin
      v = '{(c == 0) ? 8 : 0, 32'd1, 1'b1, c < 8, (c >= 2) && (c < 10), 32'(c - 1)};
      vecs.push_back(v);
    end
    run_vecs("burst");
    check("burst_count", 32'(bus.words_out), 32'd9);

    // Fill the queue under backpressure, then reset with the buffer non-empty.
    for (int c = 0; c < 4; c++) begin
      v = '{(c == 0) ? 4 : 0, 32'h50, 1'b0, c < 2, c >= 2, 32'h50};
      vecs.push_back(v);
    end
    run_vecs("prefill");
    do_reset(1'b1);
    for (int c = 0; c < 4; c++) begin
      v = '{0, 32'h0, 1'b1, c == 0, (c == 1) || (c == 2), 32'h51 + 32'(c)};
      vecs.push_back(v);
    end
    run_vecs("post_reset");
    check("post_reset_count", 32'(bus.words_out), 32'd2);
    check("post_reset_drained", 32'(exp_q.size() + src.size()), 32'd0);

    // Backpressure: ready low 10 cycles, release with a full queue.
    for (int c = 0; c < 17; c++) begin
      v = '{(c == 0) ? 6 : 0, 32'h100, c >= 10, (c < 2) || ((c >= 10) && (c < 14)),
            (c >= 2) && (c < 16), (c <= 10) ? 32'h100 : 32'h100 + 32'(c - 10)};
      vecs.push_back(v);
    end
    run_vecs("backpressure");
    check("bp_count", 32'(bus.words_out), 32'd8);

    // Random ready and buffer availability over 1000 words.
    do_reset(1'b0);
    pushed = 0;
    cyc    = 0;
    while (delivered < 1000 && cyc < 20000) begin
      tick();
      if (pushed < 1000 && $urandom_range(0, 3) != 0) begin
        n = int'($urandom_range(1, 4));
        if (n > 1000 - pushed) n = 1000 - pushed;
        for (int k = 0; k < n; k++) src.push_back($urandom);
        pushed += n;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      hold_empty    = ($urandom_range(0, 4) == 0);
      refresh_empty();
      cyc++;
    end
    hold_empty = 1'b0;
    refresh_empty();
    check("random_delivered", 32'(delivered), 32'd1000);
    check("random_count", 32'(bus.words_out), 32'd1000);
    check("random_leftover", 32'(exp_q.size() + src.size()), 32'd0);

    // 17 transfers: 16-bit counter reads 17, 4-bit counter wraps to 1.
    do_reset(1'b0);
    for (int c = 0; c < 22; c++) begin
      v = '{(c == 0) ? 17 : 0, 32'h200, 1'b1, c < 17, (c >= 2) && (c < 19), 32'h200 + 32'(c - 2)};
      vecs.push_back(v);
    end
    run_vecs("wrap");
    check("wrap_count16", 32'(bus.words_out),  32'd17);
    check("wrap_count4",  32'(bus4.words_out), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
